dmem_responder: RTL

- Memory-side responder for the pipelined CPU's data-memory port. The CPU core is the initiator; this block is the memory that answers it.
- Accepts one load or store per valid/ready handshake, waits a programmable latency, performs a byte-enabled word access, then returns a response through a second valid/ready handshake.
- Sits between the CPU's MEM stage and the data storage. The CPU stalls while a response is outstanding.

---
 rtl/dmem_pkg.sv | 14 +
 rtl/dmem_array.sv | 43 ++++
 rtl/dmem_responder.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and widths for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int WORD_W     = 32;
  localparam int BE_W       = 4;
  localparam int BYTE_OFF_W = 2;

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32-bit word storage with byte-enabled write and a registered read port.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              acc_en,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [AW-1:0]     idx,
  input  logic [WORD_W-1:0] wdata,
  input  logic [BE_W-1:0]   be,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];
  logic [WORD_W-1:0] rdata_q, rdata_d;

  // Every access edge refreshes the read register, so stores and errors return zero.
  always_comb begin
    rdata_d = rdata_q;
    if (acc_en) rdata_d = rd_en ? mem[idx] : '0;
  end

  always_ff @(posedge clk) begin
    if (acc_en && wr_en) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the CPU data port: accept, wait LATENCY edges, access, respond.
// Optional DMEM_STATS_EN adds free-running load/store/error counters.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [WORD_W-1:0] resp_rdata,
`ifdef DMEM_STATS_EN
  output logic [31:0]       rd_count,
  output logic [31:0]       wr_count,
  output logic [31:0]       err_count,
`endif
  output logic              resp_err
);

  localparam int          AW       = $clog2(DEPTH);
  localparam int          CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [31:0] DEPTH_W  = 32'(DEPTH);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic [31:0]       addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;

  logic access;
  logic addr_err;

  assign req_ready = (state_q == IDLE);
  assign access    = (state_q == BUSY) && (cnt_q == '0);
  assign addr_err  = (addr_q[BYTE_OFF_W-1:0] != '0) ||
                     ({2'b00, addr_q[31:BYTE_OFF_W]} >= DEPTH_W);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    resp_valid_d = resp_valid_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          wr_d    = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
          cnt_d   = CNT_LOAD;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          resp_valid_d = 1'b1;
          resp_err_d   = addr_err;
          state_d      = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset discards a latched request, so an in-flight store never performs its access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
    end
  end

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .reset (reset),
    .acc_en(access),
    .wr_en (wr_q && !addr_err),
    .rd_en (!wr_q && !addr_err),
    .idx   (addr_q[BYTE_OFF_W +: AW]),
    .wdata (wdata_q),
    .be    (be_q),
    .rdata (resp_rdata)
  );

  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;

`ifdef DMEM_STATS_EN
  logic [31:0] rd_count_q, rd_count_d;
  logic [31:0] wr_count_q, wr_count_d;
  logic [31:0] err_count_q, err_count_d;

  always_comb begin
    rd_count_d  = rd_count_q;
    wr_count_d  = wr_count_q;
    err_count_d = err_count_q;
    if (access) begin
      if (addr_err)  err_count_d = err_count_q + 32'd1;
      else if (wr_q) wr_count_d  = wr_count_q + 32'd1;
      else           rd_count_d  = rd_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_count_q  <= '0;
      wr_count_q  <= '0;
      err_count_q <= '0;
    end else begin
      rd_count_q  <= rd_count_d;
      wr_count_q  <= wr_count_d;
      err_count_q <= err_count_d;
    end
  end

  assign rd_count  = rd_count_q;
  assign wr_count  = wr_count_q;
  assign err_count = err_count_q;
`endif

endmodule
